nt_node_pipe: RTL and testbench
===============================

# nt_node_pipe

Parametrised, multi-lane successor to the single-bit Nt-node subcircuit used in the trojan-detection benchmarks. Each lane registers three operands, evaluates the fixed NAND/NOR cone against a late fourth operand, and registers the result through a configurable output pipeline. A valid bit travels with the data. Per-lane saturating toggle counters expose output activity, so rare-switching nodes can be flagged. The block sits in the benchmark subcircuit layer and is instantiated wherever a chain of Nt-node cells would otherwise be stamped out bit by bit.

## Interface
Parameters:
- WIDTH, 8, number of independent lanes
- DEPTH, 0, extra output register stages after the cone register (0..8)
- CNT_W, 8, width of each per-lane toggle counter

Ports:
- I1470_clk  in  1  single clock; all state is updated on its rising edge
- I1477_rst  in  1  reset, synchronous and active-high
- in_valid  in  1  qualifies a, b and c this cycle
- a  in  WIDTH  operand, registered as q1
- b  in  WIDTH  operand, registered as q2
- c  in  WIDTH  operand, registered as q3
- d  in  WIDTH  late operand, used unregistered one cycle after a, b and c
- mode  in  2  function select, sampled together with d
- cnt_clr  in  1  synchronous clear of all counters and sticky flags
- out_valid  out  1  q is valid this cycle
- q  out  WIDTH  per-lane result
- toggle_cnt  out  WIDTH*CNT_W  lane i occupies bits [i*CNT_W +: CNT_W]
- cnt_sat  out  WIDTH  sticky per-lane saturation flag

## Operation
- Stage 1: q1 <= a, q2 <= b, q3 <= c and v1 <= in_valid, on every clock edge.
- Cone, per lane, combinational: f = ((q3 & ~q2) | q1 | d) & (~q1 | q2 | d). This is the function of the original gate cone.
- Stage 2 (cone register) captures the following, selected by mode:
  - mode 0: r <= f
  - mode 1: r <= ~f
  - mode 2: r <= q1 (bypass)
  - mode 3: freeze. r holds its value and the valid bit entering stage 2 is forced to 0.
- The stage-2 valid bit is v2 <= v1 & (mode != 3).
- Output pipeline: DEPTH plain register stages carry {valid, r}. q and out_valid come from the last stage; with DEPTH = 0 they come directly from stage 2.
- Toggle counter, per lane i:
  - last_q[i] holds the q[i] of the most recent out_valid cycle.
  - When out_valid = 1 and q[i] != last_q[i], the counter increments by 1.
  - When out_valid = 1, last_q[i] <= q[i].
  - At 2^CNT_W − 1 the counter holds its value, and cnt_sat[i] is set on the first toggle that would overflow.
  - cnt_sat[i] stays set until cnt_clr or reset.
- When cnt_clr and a toggle occur in the same cycle, clear wins: the counter goes to 0, the toggle is not counted and last_q is still updated.
- Reset: every register clears to 0 on the next edge, including q1–q3, v1, r, all pipeline stages, last_q, the counters and cnt_sat. Reset applied mid-stream discards all in-flight data; out_valid stays 0 until new in_valid data reaches the output.

## Timing
- Latency from a/b/c to q is 2 + DEPTH cycles.
- d and mode must be presented exactly 1 cycle after the a/b/c they pair with.
- Throughput: 1 result per cycle. There is no backpressure.
- Reset values: q = 0, out_valid = 0, toggle_cnt = 0, cnt_sat = 0.
- A toggle is reflected in toggle_cnt 1 cycle after the out_valid cycle that carried it.
- When mode changes, only the result of the cycle in which it is sampled is affected. There is no pipeline flush.

## Structure
- Package nt_pkg holds:
  - the mode enum (NT_CONE, NT_INV, NT_BYPASS, NT_FREEZE)
  - the function nt_cone_f(q1, q2, q3, d)
  - the DEPTH bound constant
- Sub-module nt_toggle_counter: one lane of last_q, the saturating counter and the sticky flag. It is instantiated WIDTH times by generate.

## Test plan
- Cone truth, mode 0, one lane: inputs (a,b,c,d) and the required q, 2 + DEPTH cycles later:
  - (1,0,1,0) -> q = 0
  - (0,0,1,0) -> q = 1
  - (0,1,0,0) -> q = 0
  - (0,1,0,1) -> q = 1
- Modes, using the vector (0,0,1,0):
  - mode 1 -> q = 0
  - mode 2 -> q = 0 (q1)
  - mode 3 -> the previous q is held and out_valid = 0
- Latency sweep: DEPTH = 0 and DEPTH = 3, with in_valid pulsed at cycle 5 -> out_valid high exactly at cycle 7 and cycle 10 respectively, for 1 cycle.
- Saturation: CNT_W = 3, q[0] alternating for 9 valid cycles -> toggle_cnt[0] = 7 and cnt_sat[0] = 1. Then cnt_clr coincident with a toggle -> count 0, flag 0.
- Reset mid-stream: DEPTH = 2, full pipeline, I1477_rst high for 1 cycle -> on the next edge q = 0, out_valid = 0 and counters = 0. No stale out_valid appears afterwards.
- Lane independence: WIDTH = 8, a = 8'hA5, b = 8'h00, c = 8'hFF, d = 8'h00, mode 0 -> q = 8'h5A.

Source files
------------

// File: rtl/nt_pkg.sv
// Shared definitions for the Nt-node pipeline: the function select encoding,
// the single-lane gate-cone function and the output pipeline depth bound.
package nt_pkg;

    localparam int NT_DEPTH_MAX = 8;

    typedef enum logic [1:0] {
        NT_CONE   = 2'd0,
        NT_INV    = 2'd1,
        NT_BYPASS = 2'd2,
        NT_FREEZE = 2'd3
    } nt_mode_e;

    // NAND/NOR cone of the original Nt-node cell, one lane.
    function automatic logic nt_cone_f(
        input logic q1,
        input logic q2,
        input logic q3,
        input logic d
    );
        return ((q3 & ~q2) | q1 | d) & (~q1 | q2 | d);
    endfunction

endpackage

// File: rtl/nt_toggle_counter.sv
// One lane of output activity tracking: last observed value, a saturating
// toggle counter and a sticky saturation flag.
module nt_toggle_counter
    import nt_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cnt_clr,
    input  logic             valid,
    input  logic             q_bit,
    output logic [CNT_W-1:0] cnt,
    output logic             sat
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             last_q_r;
    logic [CNT_W-1:0] cnt_r;
    logic             sat_r;
    logic             toggle_s;
    logic             at_max_s;

    // Toggle detect against the last valid output, and saturation point
    always_comb begin
        toggle_s = valid & (q_bit ^ last_q_r);
        at_max_s = (cnt_r == CNT_MAX);
    end

    // Counter state; a clear in the same cycle as a toggle drops the toggle
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q_r <= 1'b0;
            cnt_r    <= {CNT_W{1'b0}};
            sat_r    <= 1'b0;
        end else begin
            if (valid) begin
                last_q_r <= q_bit;
            end else begin
                last_q_r <= last_q_r;
            end
            if (cnt_clr) begin
                cnt_r <= {CNT_W{1'b0}};
                sat_r <= 1'b0;
            end else if (toggle_s) begin
                if (at_max_s) begin
                    cnt_r <= cnt_r;
                    sat_r <= 1'b1;
                end else begin
                    cnt_r <= cnt_r + CNT_W'(1);
                    sat_r <= sat_r;
                end
            end else begin
                cnt_r <= cnt_r;
                sat_r <= sat_r;
            end
        end
    end

    assign cnt = cnt_r;
    assign sat = sat_r;

endmodule

// File: rtl/nt_node_pipe.sv
// Multi-lane Nt-node cone: registered operands, late-operand cone with mode
// select, configurable output pipeline and per-lane toggle counters.
module nt_node_pipe
    import nt_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 0,
    parameter int CNT_W = 8
) (
    input  logic                   I1470_clk,
    input  logic                   I1477_rst,
    input  logic                   in_valid,
    input  logic [WIDTH-1:0]       a,
    input  logic [WIDTH-1:0]       b,
    input  logic [WIDTH-1:0]       c,
    input  logic [WIDTH-1:0]       d,
    input  logic [1:0]             mode,
    input  logic                   cnt_clr,
    output logic                   out_valid,
    output logic [WIDTH-1:0]       q,
    output logic [WIDTH*CNT_W-1:0] toggle_cnt,
    output logic [WIDTH-1:0]       cnt_sat
);

    localparam int PIPE_DEPTH = (DEPTH > NT_DEPTH_MAX) ? NT_DEPTH_MAX : DEPTH;

    logic [WIDTH-1:0] q1_r;
    logic [WIDTH-1:0] q2_r;
    logic [WIDTH-1:0] q3_r;
    logic             v1_r;
    logic [WIDTH-1:0] f_s;
    logic [WIDTH-1:0] r_nxt_s;
    logic             v_nxt_s;
    logic [WIDTH-1:0] r_r;
    logic             v2_r;
    nt_mode_e         mode_s;

    // Stage 1: capture the early operands and their valid
    always_ff @(posedge I1470_clk) begin
        if (I1477_rst) begin
            q1_r <= {WIDTH{1'b0}};
            q2_r <= {WIDTH{1'b0}};
            q3_r <= {WIDTH{1'b0}};
            v1_r <= 1'b0;
        end else begin
            q1_r <= a;
            q2_r <= b;
            q3_r <= c;
            v1_r <= in_valid;
        end
    end

    // Cone evaluation per lane against the unregistered late operand
    always_comb begin
        f_s = {WIDTH{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            f_s[i] = nt_cone_f(q1_r[i], q2_r[i], q3_r[i], d[i]);
        end
    end

    // Stage-2 next value; freeze keeps r and kills the valid entering stage 2
    always_comb begin
        mode_s  = nt_mode_e'(mode);
        r_nxt_s = r_r;
        v_nxt_s = 1'b0;
        case (mode_s)
            NT_CONE: begin
                r_nxt_s = f_s;
                v_nxt_s = v1_r;
            end
            NT_INV: begin
                r_nxt_s = ~f_s;
                v_nxt_s = v1_r;
            end
            NT_BYPASS: begin
                r_nxt_s = q1_r;
                v_nxt_s = v1_r;
            end
            NT_FREEZE: begin
                r_nxt_s = r_r;
                v_nxt_s = 1'b0;
            end
            default: begin
                r_nxt_s = r_r;
                v_nxt_s = 1'b0;
            end
        endcase
    end

    // Stage 2: cone register
    always_ff @(posedge I1470_clk) begin
        if (I1477_rst) begin
            r_r  <= {WIDTH{1'b0}};
            v2_r <= 1'b0;
        end else begin
            r_r  <= r_nxt_s;
            v2_r <= v_nxt_s;
        end
    end

    generate
        if (PIPE_DEPTH == 0) begin : g_no_pipe
            // Outputs straight from the cone register
            always_comb begin
                out_valid = v2_r;
                q         = r_r;
            end
        end else begin : g_pipe
            logic [PIPE_DEPTH-1:0][WIDTH-1:0] pq_r;
            logic [PIPE_DEPTH-1:0]            pv_r;

            // Plain shift pipeline carrying {valid, r}
            always_ff @(posedge I1470_clk) begin
                if (I1477_rst) begin
                    pq_r <= {(PIPE_DEPTH*WIDTH){1'b0}};
                    pv_r <= {PIPE_DEPTH{1'b0}};
                end else begin
                    pq_r[0] <= r_r;
                    pv_r[0] <= v2_r;
                    for (int s = 1; s < PIPE_DEPTH; s++) begin
                        pq_r[s] <= pq_r[s-1];
                        pv_r[s] <= pv_r[s-1];
                    end
                end
            end

            // Outputs from the last pipeline stage
            always_comb begin
                out_valid = pv_r[PIPE_DEPTH-1];
                q         = pq_r[PIPE_DEPTH-1];
            end
        end
    endgenerate

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        nt_toggle_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk     (I1470_clk),
            .rst     (I1477_rst),
            .cnt_clr (cnt_clr),
            .valid   (out_valid),
            .q_bit   (q[i]),
            .cnt     (toggle_cnt[i*CNT_W +: CNT_W]),
            .sat     (cnt_sat[i])
        );
    end

endmodule

// File: tb/tb_nt_node_pipe.sv
// Scoreboard bench for nt_node_pipe: three instances (DEPTH 0/2/3) share one
// stimulus stream; a bench model predicts every output cycle and counter state.
module tb_nt_node_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        cnt_clr;
    logic [7:0]  a, b, c, d;
    logic [1:0]  mode;

    logic        ov_d0, ov_d2, ov_d3;
    logic [7:0]  q_d0, q_d2, q_d3;
    logic [23:0] tc_d0;
    logic [63:0] tc_d2, tc_d3;
    logic [7:0]  sat_d0, sat_d2, sat_d3;

    logic        ov  [3];
    logic [7:0]  oq  [3];
    logic [63:0] otc [3];
    logic [7:0]  osat[3];

    typedef struct {
        logic [7:0] q;
        logic       v;
        int         due;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];
    exp_t sb2[$];

    int   mcnt [3][8];
    logic msat [3][8];
    logic mlast[3][8];

    logic [7:0] pa, pb, pc, r_m, nd;
    logic       pv;
    logic [1:0] nmode;
    int         cyc = 0;
    int         n_chk = 0;
    int         n_pass = 0;
    bit         mon_en = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    nt_node_pipe #(.WIDTH(8), .DEPTH(0), .CNT_W(3)) u_d0 (
        .I1470_clk(clk), .I1477_rst(rst), .in_valid(in_valid), .a(a), .b(b), .c(c), .d(d),
        .mode(mode), .cnt_clr(cnt_clr), .out_valid(ov_d0), .q(q_d0), .toggle_cnt(tc_d0), .cnt_sat(sat_d0));
    nt_node_pipe #(.WIDTH(8), .DEPTH(2), .CNT_W(8)) u_d2 (
        .I1470_clk(clk), .I1477_rst(rst), .in_valid(in_valid), .a(a), .b(b), .c(c), .d(d),
        .mode(mode), .cnt_clr(cnt_clr), .out_valid(ov_d2), .q(q_d2), .toggle_cnt(tc_d2), .cnt_sat(sat_d2));
    nt_node_pipe #(.WIDTH(8), .DEPTH(3), .CNT_W(8)) u_d3 (
        .I1470_clk(clk), .I1477_rst(rst), .in_valid(in_valid), .a(a), .b(b), .c(c), .d(d),
        .mode(mode), .cnt_clr(cnt_clr), .out_valid(ov_d3), .q(q_d3), .toggle_cnt(tc_d3), .cnt_sat(sat_d3));

    assign ov[0] = ov_d0;  assign ov[1] = ov_d2;  assign ov[2] = ov_d3;
    assign oq[0] = q_d0;   assign oq[1] = q_d2;   assign oq[2] = q_d3;
    assign otc[0] = {40'd0, tc_d0};
    assign otc[1] = tc_d2;
    assign otc[2] = tc_d3;
    assign osat[0] = sat_d0; assign osat[1] = sat_d2; assign osat[2] = sat_d3;

    function automatic int cw(input int k);
        return (k == 0) ? 3 : 8;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, obs, exp);
    endtask

    // Drive one cycle: new a/b/c/in_valid plus the d/mode paired with the previous a/b/c.
    task automatic send(input logic [7:0] ia, input logic [7:0] ib, input logic [7:0] ic,
                        input logic [7:0] id, input logic [1:0] im, input logic iv, input logic iclr);
        logic [7:0] f, r;
        exp_t       e;
        a = ia; b = ib; c = ic; in_valid = iv; d = nd; mode = nmode; cnt_clr = iclr;
        f = nd | (pa & pb) | (~pa & ~pb & pc);
        case (nmode)
            2'd0:    r = f;
            2'd1:    r = ~f;
            2'd2:    r = pa;
            default: r = r_m;
        endcase
        e.q = r;
        e.v = pv && (nmode != 2'd3);
        e.due = cyc + 1; sb0.push_back(e);
        e.due = cyc + 3; sb1.push_back(e);
        e.due = cyc + 4; sb2.push_back(e);
        r_m = r; pa = ia; pb = ib; pc = ic; pv = iv; nd = id; nmode = im;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) send(8'h00, 8'h00, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0);
    endtask

    task automatic vec(input bit va, input bit vb, input bit vc, input bit vd, input logic [1:0] m);
        send({8{va}}, {8{vb}}, {8{vc}}, {8{vd}}, m, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; cnt_clr = 1'b0;
        a = 8'h00; b = 8'h00; c = 8'h00; d = 8'h00; mode = 2'd0;
        @(posedge clk); #1;
        rst = 1'b0;
        pa = 8'h00; pb = 8'h00; pc = 8'h00; pv = 1'b0; r_m = 8'h00; nd = 8'h00; nmode = 2'd0;
        sb0.delete(); sb1.delete(); sb2.delete();
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 8; i++) begin
                mcnt[k][i] = 0; msat[k][i] = 1'b0; mlast[k][i] = 1'b0;
            end
        if (mon_en) begin
            for (int k = 0; k < 3; k++) begin
                check("rst_q", oq[k], 64'd0);
                check("rst_out_valid", ov[k], 64'd0);
                check("rst_toggle_cnt", otc[k], 64'd0);
                check("rst_cnt_sat", osat[k], 64'd0);
            end
        end
        mon_en = 1'b1;
    endtask

    // Scoreboard: pop the entry due this cycle, compare, then advance the counter model
    always @(negedge clk) begin
        if (mon_en) begin
            for (int k = 0; k < 3; k++) begin
                exp_t        e;
                bit          got;
                logic [63:0] etc;
                logic [7:0]  esat;
                int          cmax;
                got = 1'b0; etc = 64'd0; esat = 8'h00; cmax = (1 << cw(k)) - 1;
                for (int i = 0; i < 8; i++) begin
                    etc  = etc | (64'(mcnt[k][i]) << (i * cw(k)));
                    esat[i] = msat[k][i];
                end
                check("toggle_cnt", otc[k], etc);
                check("cnt_sat", osat[k], esat);
                case (k)
                    0: if (sb0.size() > 0 && sb0[0].due <= cyc) begin e = sb0.pop_front(); got = 1'b1; end
                    1: if (sb1.size() > 0 && sb1[0].due <= cyc) begin e = sb1.pop_front(); got = 1'b1; end
                    default: if (sb2.size() > 0 && sb2[0].due <= cyc) begin e = sb2.pop_front(); got = 1'b1; end
                endcase
                if (got) begin
                    check("due_cycle", cyc, e.due);
                    check("out_valid", ov[k], e.v);
                    check("q", oq[k], e.q);
                end else begin
                    e.v = 1'b0; e.q = 8'h00;
                    check("idle_out_valid", ov[k], 64'd0);
                end
                for (int i = 0; i < 8; i++) begin
                    if (cnt_clr) begin
                        mcnt[k][i] = 0; msat[k][i] = 1'b0;
                    end else if (e.v && (e.q[i] != mlast[k][i])) begin
                        if (mcnt[k][i] == cmax) msat[k][i] = 1'b1;
                        else mcnt[k][i] = mcnt[k][i] + 1;
                    end
                    if (e.v) mlast[k][i] = e.q[i];
                end
            end
        end
    end

    initial begin
        int t0, hit0, hit3, n0, n3;
        rst = 1'b1; in_valid = 1'b0; cnt_clr = 1'b0;
        a = 8'h00; b = 8'h00; c = 8'h00; d = 8'h00; mode = 2'd0;
        nd = 8'h00; nmode = 2'd0; pa = 8'h00; pb = 8'h00; pc = 8'h00; pv = 1'b0; r_m = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        do_reset();

        // cone truth, mode 0
        vec(1'b1, 1'b0, 1'b1, 1'b0, 2'd0);
        vec(1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
        vec(1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
        vec(1'b0, 1'b1, 1'b0, 1'b1, 2'd0);
        // modes on (0,0,1,0); freeze follows a q = 1 result
        vec(1'b0, 1'b0, 1'b1, 1'b0, 2'd1);
        vec(1'b0, 1'b0, 1'b1, 1'b0, 2'd2);
        vec(1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
        vec(1'b0, 1'b0, 1'b1, 1'b0, 2'd3);
        idle(6);

        // latency: single valid pulse
        t0 = cyc; hit0 = -1; hit3 = -1; n0 = 0; n3 = 0;
        vec(1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
        for (int j = 0; j < 8; j++) begin
            idle(1);
            if (ov_d0) begin n0++; if (hit0 < 0) hit0 = cyc; end
            if (ov_d3) begin n3++; if (hit3 < 0) hit3 = cyc; end
        end
        check("latency_d0", hit0, t0 + 2);
        check("pulse_len_d0", n0, 64'd1);
        check("latency_d3", hit3, t0 + 5);
        check("pulse_len_d3", n3, 64'd1);

        // saturation on the CNT_W = 3 instance
        send(8'h00, 8'h00, 8'h00, 8'h00, 2'd0, 1'b0, 1'b1);
        for (int j = 0; j < 9; j++)
            send((j % 2 == 0) ? 8'hFF : 8'h00, 8'h00, 8'h00, 8'h00, 2'd2, 1'b1, 1'b0);
        idle(5);
        check("sat_cnt_lane0", otc[0] & 64'h7, 64'd7);
        check("sat_flag_lane0", osat[0] & 8'h01, 64'd1);
        send(8'h00, 8'h00, 8'h00, 8'h00, 2'd2, 1'b1, 1'b0);
        idle(1);
        send(8'h00, 8'h00, 8'h00, 8'h00, 2'd0, 1'b0, 1'b1);
        check("clr_vs_toggle_cnt", otc[0], 64'd0);
        check("clr_vs_toggle_sat", osat[0], 64'd0);
        idle(4);

        // lane independence
        send(8'hA5, 8'h00, 8'hFF, 8'h00, 2'd0, 1'b1, 1'b0);
        idle(1);
        check("lanes_q_d0", oq[0], 64'h5A);
        check("lanes_valid_d0", ov[0], 64'd1);
        idle(3);
        check("lanes_q_d3", oq[2], 64'h5A);
        idle(2);

        // random stream
        for (int j = 0; j < 80; j++)
            send(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 2'($urandom),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0));
        idle(5);

        // reset with a full pipeline
        for (int j = 0; j < 6; j++)
            send(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 2'($urandom_range(0, 2)), 1'b1, 1'b0);
        do_reset();
        idle(6);
        for (int j = 0; j < 10; j++)
            send(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 2'($urandom), 1'b1, 1'b0);
        idle(6);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
